regfile_mp: RTL and testbench

- Parametrised successor to the single-write, two-read CPU register file.
- Generalised in data width, register count and read-port count.
- Adds a synchronous hardware clear sequence after reset, a ready flag, and optional write-to-read bypass.
- Sits in the ID stage of the RV32I pipeline; feeds operand muxes, written from WB.

---
 rtl/rf_pkg.sv | 14 +
 rtl/regfile_rd_port.sv | 44 ++++
 rtl/regfile_mp.sv | 92 +++++++++
 tb/tb_regfile_mp.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared types and constants for the multi-port register file.
// Exports default sizes, FSM state encoding and the x0 index.
package rf_pkg;

  localparam int XLEN_DEFAULT  = 32;
  localparam int NREGS_DEFAULT = 32;
  localparam int ZERO_REG      = 0;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } rf_state_e;

endpackage

// File: rtl/regfile_rd_port.sv
// One asynchronous read port: decode, x0/not-ready zeroing, bypass.
// Ports: ready, addr, regs in; data out; with REGFILE_BYPASS_EN also
// we/wr_addr/wr_data for same-cycle write-through.
module regfile_rd_port
  import rf_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int NREGS = NREGS_DEFAULT,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic                        ready,
  input  logic [AW-1:0]               addr,
  input  logic [NREGS-1:0][XLEN-1:0]  regs,
`ifdef REGFILE_BYPASS_EN
  input  logic                        we,
  input  logic [AW-1:0]               wr_addr,
  input  logic [XLEN-1:0]             wr_data,
`endif
  output logic [XLEN-1:0]             data
);

  localparam logic [AW-1:0] X0 = AW'(ZERO_REG);

  logic hit;

`ifdef REGFILE_BYPASS_EN
  assign hit = ready & we & (wr_addr != X0) &
               (wr_addr == addr);
`else
  assign hit = 1'b0;
`endif

  always_comb begin
    data = '0;
    unique case (1'b1)
`ifdef REGFILE_BYPASS_EN
      hit:                         data = wr_data;
`endif
      (!hit && ready && addr != X0): data = regs[addr];
      default:                     data = '0;
    endcase
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file with post-reset clear FSM and NRD read ports.
// Ports: clk, rst, RegWrite/rd/rd_write_data in; rs_addr in; rs_data,
// ready out. Optional macro REGFILE_BYPASS_EN enables write-through.
module regfile_mp
  import rf_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int NREGS = NREGS_DEFAULT,
  parameter int NRD   = 2,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                RegWrite,
  input  logic [AW-1:0]       rd,
  input  logic [XLEN-1:0]     rd_write_data,
  input  logic [NRD*AW-1:0]   rs_addr,
  output logic [NRD*XLEN-1:0] rs_data,
  output logic                ready
);

  localparam logic [AW-1:0] LAST = AW'(NREGS-1);
  localparam logic [AW-1:0] X0   = AW'(ZERO_REG);

  rf_state_e                  state_q, state_d;
  logic [AW-1:0]              clr_idx_q, clr_idx_d;
  logic                       ready_q, ready_d;
  logic                       clr_we, wr_en;
  logic [NREGS-1:0][XLEN-1:0] regs;

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    ready_d   = ready_q;
    clr_we    = 1'b0;
    unique case (state_q)
      RF_CLEAR: begin
        clr_we    = 1'b1;
        clr_idx_d = clr_idx_q + AW'(1);
        if (clr_idx_q == LAST) begin
          state_d = RF_READY;
          ready_d = 1'b1;
        end
      end
      RF_READY: ready_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RF_CLEAR;
      clr_idx_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      ready_q   <= ready_d;
    end
  end

  // Storage has no reset of its own; the clear walk zeroes it.
  assign wr_en = ~rst & (state_q == RF_READY) &
                 RegWrite & (rd != X0);

  always_ff @(posedge clk) begin
    if (!rst && clr_we)
      regs[clr_idx_q] <= '0;
    else if (wr_en)
      regs[rd] <= rd_write_data;
  end

  assign ready = ready_q;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    regfile_rd_port #(
      .XLEN  (XLEN),
      .NREGS (NREGS),
      .AW    (AW)
    ) u_port (
      .ready   (ready_q),
      .addr    (rs_addr[k*AW +: AW]),
      .regs    (regs),
`ifdef REGFILE_BYPASS_EN
      .we      (RegWrite),
      .wr_addr (rd),
      .wr_data (rd_write_data),
`endif
      .data    (rs_data[k*XLEN +: XLEN])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: default build plus a
// 64-bit / 16-entry / 3-port instance, against an array model.
module tb_regfile_mp;

  localparam int XL  = 32;
  localparam int NR  = 32;
  localparam int ND  = 2;
  localparam int AW  = 5;
  localparam int RAW = ND*AW;

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, we;
  logic [AW-1:0] rd;
  logic [XL-1:0] wd;
  logic [RAW-1:0] ra;
  logic [ND*XL-1:0] rdata;
  logic          rdy;

  logic          rst2, we2;
  logic [3:0]    rd2;
  logic [63:0]   wd2;
  logic [11:0]   ra2;
  logic [191:0]  rdata2;
  logic          rdy2;

  regfile_mp dut (
    .clk           (clk),
    .rst           (rst),
    .RegWrite      (we),
    .rd            (rd),
    .rd_write_data (wd),
    .rs_addr       (ra),
    .rs_data       (rdata),
    .ready         (rdy)
  );

  regfile_mp #(.XLEN(64), .NREGS(16), .NRD(3)) dut2 (
    .clk           (clk),
    .rst           (rst2),
    .RegWrite      (we2),
    .rd            (rd2),
    .rd_write_data (wd2),
    .rs_addr       (ra2),
    .rs_data       (rdata2),
    .ready         (rdy2)
  );

  int tests = 0;
  int fails = 0;

  logic [XL-1:0] model [NR];
  bit            m_ready = 1'b0;
  int            m_cnt   = 0;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [XL-1:0] exp_rd(input int a, input bit w,
                                           input int wa,
                                           input logic [XL-1:0] d);
    logic [XL-1:0] v;
    v = '0;
    if (m_ready && a != 0) v = model[a];
`ifdef REGFILE_BYPASS_EN
    if (m_ready && w && wa != 0 && wa == a) v = d;
`endif
    return v;
  endfunction

  task automatic tick(input bit r, input bit w, input int a,
                      input logic [XL-1:0] d, input bit chk);
    rst = r; we = w; rd = AW'(a); wd = d;
    #1;
    if (chk)
      for (int k = 0; k < ND; k++)
        check($sformatf("rd_p%0d", k), 64'(rdata[k*XL +: XL]),
              64'(exp_rd(int'(ra[k*AW +: AW]), w, a, d)));
    @(posedge clk);
    if (r) begin
      m_ready = 1'b0;
      m_cnt   = 0;
    end else if (!m_ready) begin
      m_cnt++;
      if (m_cnt == NR) begin
        m_ready = 1'b1;
        for (int i = 0; i < NR; i++) model[i] = '0;
      end
    end else if (w && a != 0) begin
      model[a] = d;
    end
    #1;
    if (chk) check("ready", 64'(rdy), 64'(m_ready));
    @(negedge clk);
  endtask

  task automatic wait_ready(input int exp_n, input string tag,
                            input bit inject);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      ra = RAW'($urandom);
      if (inject && i == 10)
        tick(1'b0, 1'b1, 31, 32'h12345678, 1'b1);
      else
        tick(1'b0, 1'($urandom), int'($urandom_range(0, NR-1)),
             $urandom, 1'b1);
      n++;
      if (rdy) done = 1'b1;
    end
    check(tag, 64'(n), 64'(exp_n));
  endtask

  task automatic rand_ops(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      ra = RAW'($urandom);
      tick(1'b0, 1'($urandom), int'($urandom_range(0, NR-1)),
           $urandom, 1'b1);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n2;
    rst = 1'b1; we = 1'b0; rd = '0; wd = '0; ra = '0;
    rst2 = 1'b0; we2 = 1'b0; rd2 = '0; wd2 = '0; ra2 = '0;
    @(negedge clk);

    tick(1'b1, 1'b0, 0, '0, 1'b0);
    tick(1'b1, 1'b0, 0, '0, 1'b1);
    tick(1'b1, 1'b0, 0, '0, 1'b1);
    wait_ready(NR, "clear_len0", 1'b0);
    rand_ops(150);

    for (int i = 1; i < NR; i++) tick(1'b0, 1'b1, i, $urandom, 1'b1);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 7, $urandom, 1'b1);
    wait_ready(NR, "clear_len1", 1'b1);
    ra = {AW'(31), AW'(31)};
    #1 check("r31_after_clr", 64'(rdata), 64'h0);
    for (int i = 0; i < NR; i++) begin
      ra = {AW'(i), AW'(i)};
      tick(1'b0, 1'b0, 0, '0, 1'b1);
      check("zero_all", 64'(rdata), 64'h0);
    end

    ra = {AW'(5), AW'(5)};
    tick(1'b0, 1'b1, 5, 32'hDEADBEEF, 1'b1);
    tick(1'b0, 1'b0, 0, '0, 1'b1);
    check("wb_p0", 64'(rdata[31:0]), 64'hDEADBEEF);
    check("wb_p1", 64'(rdata[63:32]), 64'hDEADBEEF);

    ra = {AW'(0), AW'(0)};
    tick(1'b0, 1'b1, 0, 32'hFFFFFFFF, 1'b1);
    tick(1'b0, 1'b0, 0, '0, 1'b1);
    check("x0_read", 64'(rdata), 64'h0);

    rand_ops(150);

    tick(1'b1, 1'b0, 0, '0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      ra = RAW'($urandom);
      tick(1'b0, 1'b1, int'($urandom_range(1, NR-1)), $urandom, 1'b1);
    end
    tick(1'b1, 1'b0, 0, '0, 1'b1);
    wait_ready(NR, "clear_restart", 1'b0);
    rand_ops(150);

    rst2 = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rst2 = 1'b0;
    #1 check("p_rdy_rst", 64'(rdy2), 64'h0);
    n2 = 0;
    for (int i = 0; i < 100 && !rdy2; i++) begin
      @(posedge clk); #1;
      n2++;
    end
    check("p_clear_len", 64'(n2), 64'd16);
    @(negedge clk);
    ra2 = {4'd15, 4'd15, 4'd15};
    #1 check("p_pre", rdata2, 192'h0);
    we2 = 1'b1; rd2 = 4'd15; wd2 = 64'h0123456789ABCDEF;
    @(negedge clk);
    we2 = 1'b0;
    #1;
    for (int k = 0; k < 3; k++)
      check($sformatf("p_port%0d", k), rdata2[k*64 +: 64],
            64'h0123456789ABCDEF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
